// File: rtl/lcd_pkg.sv
// Shared types, constants and address helpers for the HD44780-compatible bus responder.
// AC is kept in HD44780 DDRAM coordinates: line 0 = 0x00..0x27, line 1 = 0x40..0x67.
package lcd_pkg;

   typedef enum logic [1:0] {
      IDLE,
      EXEC,
      CLEARING
   } state_t;

   typedef enum logic [3:0] {
      CMD_NOP,
      CMD_CLEAR,
      CMD_HOME,
      CMD_ENTRY,
      CMD_DISP,
      CMD_SHIFT,
      CMD_FUNC,
      CMD_CGRAM,
      CMD_DDRAM
   } cmd_t;

   localparam logic [7:0] SPACE_CHAR = 8'h20;
   localparam logic [6:0] LINE2_BASE = 7'h40;
   localparam logic [6:0] LINE1_LAST = 7'h27;
   localparam logic [6:0] LINE2_LAST = 7'h67;

   // Instruction class is selected by the highest set bit of the byte.
   function automatic cmd_t cmd_decode(input logic [7:0] d);
      cmd_t c;
      if (d[7])      c = CMD_DDRAM;
      else if (d[6]) c = CMD_CGRAM;
      else if (d[5]) c = CMD_FUNC;
      else if (d[4]) c = CMD_SHIFT;
      else if (d[3]) c = CMD_DISP;
      else if (d[2]) c = CMD_ENTRY;
      else if (d[1]) c = CMD_HOME;
      else if (d[0]) c = CMD_CLEAR;
      else           c = CMD_NOP;
      return c;
   endfunction

   function automatic logic [6:0] ac_step(input logic [6:0] ac, input logic inc);
      logic [6:0] r;
      if (inc) begin
         if (ac == LINE1_LAST)      r = LINE2_BASE;
         else if (ac == LINE2_LAST) r = 7'h00;
         else                       r = ac + 7'd1;
      end else begin
         if (ac == 7'h00)           r = LINE2_LAST;
         else if (ac == LINE2_BASE) r = LINE1_LAST;
         else                       r = ac - 7'd1;
      end
      return r;
   endfunction

   // Holes in the address map snap down to the last valid column of their line.
   function automatic logic [6:0] ac_clamp(input logic [6:0] a);
      logic [6:0] r;
      r = a;
      if (!a[6] && (a > LINE1_LAST)) r = LINE1_LAST;
      if (a[6] && (a > LINE2_LAST))  r = LINE2_LAST;
      return r;
   endfunction

   function automatic logic ac_stored(input logic [6:0] ac);
      return (ac[5:4] == 2'b00);
   endfunction

   function automatic logic [4:0] ddram_index(input logic [6:0] ac);
      return {ac[6], ac[3:0]};
   endfunction

endpackage

// File: rtl/lcd_ddram.sv
// 32x8 character store: one synchronous write port, one registered mirror read port,
// and one combinational port used to answer bus data reads at the current AC.
module lcd_ddram
   import lcd_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       we_i,
   input  logic [4:0] waddr_i,
   input  logic [7:0] wdata_i,
   input  logic [4:0] mirror_addr_i,
   output logic [7:0] mirror_data_o,
   input  logic [4:0] bus_addr_i,
   output logic [7:0] bus_data_o
);

   logic [7:0] mem_q [0:31];
   logic [7:0] mirror_q;

   always_ff @(posedge clk) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
   end

   // Non-blocking read of mem_q returns the pre-write value on a same-cycle collision.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) mirror_q <= '0;
      else        mirror_q <= mem_q[mirror_addr_i];
   end

   assign mirror_data_o = mirror_q;
   assign bus_data_o    = mem_q[bus_addr_i];

endmodule

// File: rtl/lcd_bus_responder.sv
// LCD-side end of an HD44780 parallel bus: decodes instructions, keeps a 2x16 DDRAM,
// models busy timing and answers status/data reads.
module lcd_bus_responder
   import lcd_pkg::*;
#(
   parameter int BUSY_CYCLES       = 1850,
   parameter int CLEAR_BUSY_CYCLES = 76000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] lcd_data,
   input  logic       lcd_rs,
   input  logic       lcd_rw,
   input  logic       lcd_e,
   output logic [7:0] lcd_dout,
   output logic       lcd_dout_en,
   output logic       busy,
   output logic [6:0] addr_counter,
   output logic       display_on,
   output logic       cursor_on,
   output logic       blink_on,
   output logic [2:0] func_bits,
   output logic       cmd_dropped,
   input  logic [4:0] rd_addr,
   output logic [7:0] rd_char
);

   localparam int MAX_CYC = (BUSY_CYCLES > CLEAR_BUSY_CYCLES) ? BUSY_CYCLES : CLEAR_BUSY_CYCLES;
   localparam int CW      = $clog2(MAX_CYC + 1);
   localparam logic [CW-1:0] BUSY_LOAD  = CW'(BUSY_CYCLES);
   localparam logic [CW-1:0] CLEAR_LOAD = CW'(CLEAR_BUSY_CYCLES);

   // e is synchronised; rs/rw/data get the same two-stage delay to stay aligned with it.
   logic       e_s1_q, e_s2_q, e_s3_q;
   logic       rs_s1_q, rs_s2_q, rw_s1_q, rw_s2_q;
   logic [7:0] data_s1_q, data_s2_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         e_s1_q    <= 1'b0;
         e_s2_q    <= 1'b0;
         e_s3_q    <= 1'b0;
         rs_s1_q   <= 1'b0;
         rs_s2_q   <= 1'b0;
         rw_s1_q   <= 1'b0;
         rw_s2_q   <= 1'b0;
         data_s1_q <= '0;
         data_s2_q <= '0;
      end else begin
         e_s1_q    <= lcd_e;
         e_s2_q    <= e_s1_q;
         e_s3_q    <= e_s2_q;
         rs_s1_q   <= lcd_rs;
         rs_s2_q   <= rs_s1_q;
         rw_s1_q   <= lcd_rw;
         rw_s2_q   <= rw_s1_q;
         data_s1_q <= lcd_data;
         data_s2_q <= data_s1_q;
      end
   end

   logic e_fall, e_rise, wr_strobe, rd_rise, rd_fall;
   assign e_fall    = e_s3_q & ~e_s2_q;
   assign e_rise    = ~e_s3_q & e_s2_q;
   assign wr_strobe = e_fall & ~rw_s2_q;
   assign rd_rise   = e_rise & rw_s2_q;
   assign rd_fall   = e_fall & rw_s2_q;

   state_t        state_q;
   logic [CW-1:0] cnt_q;
   logic          busy_q;
   logic [6:0]    ac_q;
   logic          id_q, disp_q, curs_q, blink_q, cg_mode_q;
   logic [2:0]    func_q;
   logic [7:0]    dout_q;
   logic          dout_en_q, dropped_q;
   logic          clr_active_q;
   logic [4:0]    clr_idx_q;

   cmd_t       cmd;
   logic       ram_we;
   logic [4:0] ram_waddr;
   logic [7:0] ram_wdata, ram_bus_data, ac_char;

   assign cmd = cmd_decode(data_s2_q);

   // The clear/reset fill owns the write port; bus writes cannot collide since busy is high.
   always_comb begin
      ram_we    = 1'b0;
      ram_waddr = ddram_index(ac_q);
      ram_wdata = data_s2_q;
      if (clr_active_q) begin
         ram_we    = 1'b1;
         ram_waddr = clr_idx_q;
         ram_wdata = SPACE_CHAR;
      end else if (wr_strobe && !busy_q && rs_s2_q && !cg_mode_q && ac_stored(ac_q)) begin
         ram_we = 1'b1;
      end
   end

   assign ac_char = ac_stored(ac_q) ? ram_bus_data : SPACE_CHAR;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= CLEARING;
         cnt_q        <= CLEAR_LOAD;
         busy_q       <= 1'b1;
         ac_q         <= '0;
         id_q         <= 1'b1;
         disp_q       <= 1'b0;
         curs_q       <= 1'b0;
         blink_q      <= 1'b0;
         cg_mode_q    <= 1'b0;
         func_q       <= 3'b000;
         dout_q       <= '0;
         dout_en_q    <= 1'b0;
         dropped_q    <= 1'b0;
         clr_active_q <= 1'b1;
         clr_idx_q    <= '0;
      end else begin
         dropped_q <= wr_strobe & busy_q;

         if (clr_active_q) begin
            clr_idx_q <= clr_idx_q + 5'd1;
            if (clr_idx_q == 5'd31) clr_active_q <= 1'b0;
         end

         case (state_q)
            IDLE: begin
               if (wr_strobe) begin
                  state_q <= EXEC;
                  cnt_q   <= BUSY_LOAD;
                  busy_q  <= 1'b1;
                  if (rs_s2_q) begin
                     if (!cg_mode_q) ac_q <= ac_step(ac_q, id_q);
                  end else begin
                     case (cmd)
                        CMD_CLEAR: begin
                           state_q      <= CLEARING;
                           cnt_q        <= CLEAR_LOAD;
                           clr_active_q <= 1'b1;
                           clr_idx_q    <= '0;
                           ac_q         <= '0;
                           id_q         <= 1'b1;
                        end
                        CMD_HOME: begin
                           state_q <= CLEARING;
                           cnt_q   <= CLEAR_LOAD;
                           ac_q    <= '0;
                        end
                        CMD_ENTRY: id_q <= data_s2_q[1];
                        CMD_DISP: begin
                           disp_q  <= data_s2_q[2];
                           curs_q  <= data_s2_q[1];
                           blink_q <= data_s2_q[0];
                        end
                        CMD_SHIFT: begin
                           if (!data_s2_q[3]) ac_q <= ac_step(ac_q, data_s2_q[2]);
                        end
                        CMD_FUNC:  func_q    <= data_s2_q[4:2];
                        CMD_CGRAM: cg_mode_q <= 1'b1;
                        CMD_DDRAM: begin
                           ac_q      <= ac_clamp(data_s2_q[6:0]);
                           cg_mode_q <= 1'b0;
                        end
                        default: ;
                     endcase
                  end
               end
            end
            EXEC, CLEARING: begin
               if (cnt_q <= CW'(1)) begin
                  state_q <= IDLE;
                  cnt_q   <= '0;
                  busy_q  <= 1'b0;
               end else begin
                  cnt_q <= cnt_q - CW'(1);
               end
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
         endcase

         // Reads are served in any state; a data read advances AC when e drops.
         if (rd_rise) begin
            dout_en_q <= 1'b1;
            dout_q    <= rs_s2_q ? ac_char : {busy_q, ac_q};
         end
         if (e_fall) dout_en_q <= 1'b0;
         if (rd_fall && rs_s2_q) ac_q <= ac_step(ac_q, id_q);
      end
   end

   lcd_ddram u_ddram (
      .clk           (clk),
      .rst_n         (rst_n),
      .we_i          (ram_we),
      .waddr_i       (ram_waddr),
      .wdata_i       (ram_wdata),
      .mirror_addr_i (rd_addr),
      .mirror_data_o (rd_char),
      .bus_addr_i    (ddram_index(ac_q)),
      .bus_data_o    (ram_bus_data)
   );

   assign lcd_dout     = dout_q;
   assign lcd_dout_en  = dout_en_q;
   assign busy         = busy_q;
   assign addr_counter = ac_q;
   assign display_on   = disp_q;
   assign cursor_on    = curs_q;
   assign blink_on     = blink_q;
   assign func_bits    = func_q;
   assign cmd_dropped  = dropped_q;

endmodule

// File: tb/tb_lcd_bus_responder.sv
// Directed plus randomized bench for lcd_bus_responder against a linear-address reference model.
module tb_lcd_bus_responder;

   localparam int BUSY_N  = 60;
   localparam int CLEAR_N = 100;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] lcd_data;
   logic       lcd_rs, lcd_rw, lcd_e;
   logic [7:0] lcd_dout;
   logic       lcd_dout_en, busy, display_on, cursor_on, blink_on, cmd_dropped;
   logic [6:0] addr_counter;
   logic [2:0] func_bits;
   logic [4:0] rd_addr;
   logic [7:0] rd_char;

   always #5 clk = ~clk;

   lcd_bus_responder #(.BUSY_CYCLES(BUSY_N), .CLEAR_BUSY_CYCLES(CLEAR_N)) dut (
      .clk(clk), .rst_n(rst_n), .lcd_data(lcd_data), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw),
      .lcd_e(lcd_e), .lcd_dout(lcd_dout), .lcd_dout_en(lcd_dout_en), .busy(busy),
      .addr_counter(addr_counter), .display_on(display_on), .cursor_on(cursor_on),
      .blink_on(blink_on), .func_bits(func_bits), .cmd_dropped(cmd_dropped),
      .rd_addr(rd_addr), .rd_char(rd_char)
   );

   int checks = 0;
   int errors = 0;

   // Reference model: AC is handled as a linear position 0..79 around both lines.
   logic [7:0] m_ram [0:31];
   logic [6:0] m_ac;
   logic       m_id, m_d, m_c, m_b, m_cg;
   logic [2:0] m_func;

   int busy_run = 0;
   int last_run = 0;
   int drop_cnt = 0;

   always @(negedge clk) begin
      if (!rst_n) busy_run = 0;
      else if (busy === 1'b1) busy_run++;
      else if (busy_run != 0) begin
         last_run = busy_run;
         busy_run = 0;
      end
      if (cmd_dropped === 1'b1) drop_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic int lin(input logic [6:0] a);
      return a[6] ? (int'(a[5:0]) + 40) : int'(a);
   endfunction

   function automatic logic [6:0] unlin(input int p);
      return (p < 40) ? 7'(p) : 7'(p - 40 + 64);
   endfunction

   task automatic m_step(input logic inc);
      m_ac = unlin(inc ? ((lin(m_ac) + 1) % 80) : ((lin(m_ac) + 79) % 80));
   endtask

   task automatic m_reset();
      for (int i = 0; i < 32; i++) m_ram[i] = 8'h20;
      m_ac = 7'h00; m_id = 1'b1; m_cg = 1'b0;
      m_d = 1'b0; m_c = 1'b0; m_b = 1'b0; m_func = 3'b000;
   endtask

   // Returns the busy length the accepted write should produce.
   task automatic m_apply(input logic rs, input logic [7:0] d, output int exp_busy);
      logic [6:0] a;
      exp_busy = BUSY_N;
      if (rs) begin
         if (!m_cg) begin
            if (m_ac[5:0] < 6'd16) m_ram[(m_ac[6] ? 16 : 0) + int'(m_ac[3:0])] = d;
            m_step(m_id);
         end
      end else if (d >= 8'h80) begin
         a = d[6:0];
         if (a >= 7'h68) a = 7'h67;
         else if (a >= 7'h28 && a < 7'h40) a = 7'h27;
         m_ac = a; m_cg = 1'b0;
      end else if (d >= 8'h40) m_cg = 1'b1;
      else if (d >= 8'h20) m_func = d[4:2];
      else if (d >= 8'h10) begin
         if (!d[3]) m_step(d[2]);
      end else if (d >= 8'h08) {m_d, m_c, m_b} = d[2:0];
      else if (d >= 8'h04) m_id = d[1];
      else if (d >= 8'h02) begin
         m_ac = 7'h00; exp_busy = CLEAR_N;
      end else if (d == 8'h01) begin
         for (int i = 0; i < 32; i++) m_ram[i] = 8'h20;
         m_ac = 7'h00; m_id = 1'b1; exp_busy = CLEAR_N;
      end
   endtask

   task automatic bus_write(input logic rs, input logic [7:0] d);
      @(negedge clk);
      lcd_rs = rs; lcd_rw = 1'b0; lcd_data = d;
      repeat (2) @(negedge clk);
      #2 lcd_e = 1'b1;
      repeat (4) @(negedge clk);
      #3 lcd_e = 1'b0;
      repeat (8) @(negedge clk);
   endtask

   task automatic wait_idle(input string tag);
      int n = 0;
      while (busy !== 1'b0 && n < 1000) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_timeout"}, 32'(n < 1000), 32'd1);
      @(negedge clk);
   endtask

   task automatic do_write(input string tag, input logic rs, input logic [7:0] d);
      int eb;
      bus_write(rs, d);
      m_apply(rs, d, eb);
      wait_idle(tag);
      check({tag, "_busy_len"}, 32'(last_run), 32'(eb));
   endtask

   task automatic bus_read(input logic rs, output logic [7:0] dout, output logic en_on,
                           output logic en_off);
      @(negedge clk);
      lcd_rs = rs; lcd_rw = 1'b1;
      repeat (2) @(negedge clk);
      #2 lcd_e = 1'b1;
      repeat (5) @(negedge clk);
      dout = lcd_dout; en_on = lcd_dout_en;
      #3 lcd_e = 1'b0;
      repeat (6) @(negedge clk);
      en_off = lcd_dout_en;
      lcd_rw = 1'b0;
   endtask

   task automatic rd_mirror(input logic [4:0] a, output logic [7:0] v);
      @(negedge clk);
      rd_addr = a;
      @(negedge clk);
      v = rd_char;
   endtask

   task automatic check_state(input string tag);
      check({tag, "_ac"}, 32'(addr_counter), 32'(m_ac));
      check({tag, "_dcb"}, 32'({display_on, cursor_on, blink_on}), 32'({m_d, m_c, m_b}));
      check({tag, "_func"}, 32'(func_bits), 32'(m_func));
   endtask

   task automatic check_ram(input string tag);
      logic [7:0] v;
      for (int i = 0; i < 32; i++) begin
         rd_mirror(5'(i), v);
         check($sformatf("%s_%0d", tag, i), 32'(v), 32'(m_ram[i]));
      end
   endtask

   initial begin
      logic [7:0] v, dout;
      logic       en_on, en_off;
      logic [7:0] d;
      logic       rs;
      int         d0, eb, sel;

      lcd_e = 1'b0; lcd_rs = 1'b0; lcd_rw = 1'b0; lcd_data = 8'h00; rd_addr = 5'd0;
      m_reset();
      repeat (3) @(negedge clk);
      check("rst_busy", 32'(busy), 32'd1);
      check("rst_ac", 32'(addr_counter), 32'd0);
      check("rst_dcb", 32'({display_on, cursor_on, blink_on}), 32'd0);
      check("rst_func", 32'(func_bits), 32'd0);
      check("rst_dout", 32'({lcd_dout_en, lcd_dout}), 32'd0);
      check("rst_dropped", 32'(cmd_dropped), 32'd0);
      check("rst_rd_char", 32'(rd_char), 32'd0);

      @(posedge clk);
      #2 rst_n = 1'b1;
      wait_idle("reset");
      check("reset_busy_len", 32'(last_run), 32'(CLEAR_N));
      check_ram("ram_after_reset");
      check("ac_after_reset", 32'(addr_counter), 32'd0);

      do_write("init_3c", 1'b0, 8'h3C);
      do_write("init_06", 1'b0, 8'h06);
      do_write("init_01", 1'b0, 8'h01);
      do_write("init_0f", 1'b0, 8'h0F);
      check("init_func", 32'(func_bits), 32'h7);
      check("init_dcb", 32'({display_on, cursor_on, blink_on}), 32'h7);
      check("init_ac", 32'(addr_counter), 32'h0);

      do_write("data_05", 1'b1, 8'h05);
      rd_mirror(5'd0, v);
      check("mirror0_05", 32'(v), 32'h05);
      check("ac_after_05", 32'(addr_counter), 32'h01);

      do_write("ddram_8f", 1'b0, 8'h8F);
      do_write("data_41", 1'b1, 8'h41);
      do_write("data_42", 1'b1, 8'h42);
      rd_mirror(5'd15, v);
      check("mirror15_41", 32'(v), 32'h41);
      check("ac_after_42", 32'(addr_counter), 32'h11);
      do_write("ddram_c0", 1'b0, 8'hC0);
      do_write("data_43", 1'b1, 8'h43);
      rd_mirror(5'd16, v);
      check("mirror16_43", 32'(v), 32'h43);

      do_write("entry_04", 1'b0, 8'h04);
      do_write("ddram_80", 1'b0, 8'h80);
      do_write("data_58", 1'b1, 8'h58);
      check("ac_wrap_67", 32'(addr_counter), 32'h67);
      do_write("ddram_a7", 1'b0, 8'hA7);
      check("ac_clamp_27", 32'(addr_counter), 32'h27);
      do_write("data_59", 1'b1, 8'h59);
      check("ac_after_59", 32'(addr_counter), 32'h26);

      do_write("ddram_80b", 1'b0, 8'h80);
      bus_read(1'b1, dout, en_on, en_off);
      check("data_read", 32'(dout), 32'(m_ram[0]));
      check("data_read_en_on", 32'(en_on), 32'd1);
      check("data_read_en_off", 32'(en_off), 32'd0);
      m_step(m_id);
      check("ac_after_read", 32'(addr_counter), 32'(m_ac));

      bus_write(1'b0, 8'h06);
      m_apply(1'b0, 8'h06, eb);
      d0 = drop_cnt;
      bus_write(1'b0, 8'h85);
      bus_read(1'b0, dout, en_on, en_off);
      check("status_read_busy", 32'(dout), 32'({1'b1, m_ac}));
      check("status_en_on", 32'(en_on), 32'd1);
      check("status_en_off", 32'(en_off), 32'd0);
      wait_idle("drop");
      check("drop_pulses", 32'(drop_cnt - d0), 32'd1);
      check_state("after_drop");

      for (int it = 0; it < 40; it++) begin
         rs = 1'($urandom_range(0, 1));
         d = 8'($urandom_range(0, 255));
         if (!rs) begin
            sel = int'($urandom_range(0, 11));
            case (sel)
               0:       d = 8'h01;
               1:       d = 8'h02 | (d & 8'h01);
               2, 3:    d = 8'h04 | (d & 8'h03);
               4:       d = 8'h08 | (d & 8'h07);
               5, 6:    d = 8'h10 | (d & 8'h0F);
               7:       d = 8'h20 | (d & 8'h1F);
               8:       d = 8'h40 | (d & 8'h3F);
               default: d = 8'h80 | (d & 8'h7F);
            endcase
         end
         do_write($sformatf("rnd%0d", it), rs, d);
         check_state($sformatf("rnd%0d", it));
      end

      check_ram("ram_final");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
